// File: rtl/dtl_pkg.sv
// Shared DTL definitions: state encoding, command polarity, widths.
// Imported by the master interface and its beat counter.
package dtl_pkg;

    localparam int DTL_DATA_W  = 32;
    localparam int DTL_ADDR_W  = 32;
    localparam int DTL_BLOCK_W = 5;

    // CommandReadWrite level that requests a read
    localparam logic DTL_CMD_READ = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CMD   = 2'b01,
        ST_READ  = 2'b10,
        ST_WRITE = 2'b11
    } dtl_state_e;

endpackage

// File: rtl/dtl_beat_counter.sv
// Burst beat counter: cleared on request, +1 per beat, flags last beat.
// Ports: iClk, iReset_n, iClear, iIncr, iSize (words-1), oLast.
module dtl_beat_counter
    import dtl_pkg::*;
#(
    parameter int W = DTL_BLOCK_W
) (
    input  logic         iClk,
    input  logic         iReset_n,
    input  logic         iClear,
    input  logic         iIncr,
    input  logic [W-1:0] iSize,
    output logic         oLast
);

    logic [W-1:0] r_count;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_count <= '0;
        end else if (iClear) begin
            r_count <= '0;
        end else if (iIncr) begin
            r_count <= r_count + 1'b1;
        end
    end

    // size=all-ones reaches last at 2^W-1 before any wrap
    assign oLast = (r_count == iSize);

endmodule

// File: rtl/dtl_master_interface.sv
// DTL initiator: one command per local burst, then streams write/read beats.
// Ports: local req/wr/rd channels, DTL cmd/read/write channels, oBusy, oError.
module dtl_master_interface
    import dtl_pkg::*;
#(
    parameter int INTERFACE_WIDTH       = DTL_DATA_W,
    parameter int INTERFACE_ADDR_WIDTH  = DTL_ADDR_W,
    parameter int INTERFACE_BLOCK_WIDTH = DTL_BLOCK_W,
    parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8
) (
    input  logic                             iClk,
    input  logic                             iReset_n,
    input  logic                             iReqValid,
    output logic                             oReqReady,
    input  logic                             iReqRead,
    input  logic [INTERFACE_ADDR_WIDTH-1:0]  iReqAddr,
    input  logic [INTERFACE_BLOCK_WIDTH-1:0] iReqBlockSize,
    input  logic                             iWrValid,
    output logic                             oWrReady,
    input  logic [INTERFACE_WIDTH-1:0]       iWrData,
    input  logic [INTERFACE_NUM_ENABLES-1:0] iWrEnable,
    output logic                             oRdValid,
    input  logic                             iRdReady,
    output logic [INTERFACE_WIDTH-1:0]       oRdData,
    output logic                             oRdLast,
    output logic                             oDTL_CommandValid,
    input  logic                             iDTL_CommandAccept,
    output logic [INTERFACE_ADDR_WIDTH-1:0]  oDTL_Address,
    output logic                             oDTL_CommandReadWrite,
    output logic [INTERFACE_BLOCK_WIDTH-1:0] oDTL_BlockSize,
    input  logic                             iDTL_ReadValid,
    input  logic                             iDTL_ReadLast,
    output logic                             oDTL_ReadAccept,
    input  logic [INTERFACE_WIDTH-1:0]       iDTL_ReadData,
    output logic                             oDTL_WriteValid,
    output logic                             oDTL_WriteLast,
    input  logic                             iDTL_WriteAccept,
    output logic [INTERFACE_NUM_ENABLES-1:0] oDTL_WriteEnable,
    output logic [INTERFACE_WIDTH-1:0]       oDTL_WriteData,
    output logic                             oBusy,
    output logic                             oError
);

    dtl_state_e                       r_state;
    dtl_state_e                       w_next;
    logic [INTERFACE_ADDR_WIDTH-1:0]  r_addr;
    logic [INTERFACE_BLOCK_WIDTH-1:0] r_size;
    logic                             r_rw;
    logic                             r_error;

    logic w_req_fire;
    logic w_in_wr;
    logic w_in_rd;
    logic w_wr_beat;
    logic w_rd_beat;
    logic w_last;

    assign w_req_fire = (r_state == ST_IDLE) & iReqValid;
    assign w_in_wr    = (r_state == ST_WRITE);
    assign w_in_rd    = (r_state == ST_READ);
    assign w_wr_beat  = w_in_wr & iWrValid & iDTL_WriteAccept;
    assign w_rd_beat  = w_in_rd & iDTL_ReadValid & iRdReady;

    dtl_beat_counter #(
        .W (INTERFACE_BLOCK_WIDTH)
    ) u_cnt (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iClear   (w_req_fire),
        .iIncr    (w_wr_beat | w_rd_beat),
        .iSize    (r_size),
        .oLast    (w_last)
    );

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_size  <= '0;
            r_rw    <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_req_fire) begin
                r_addr <= iReqAddr;
                r_size <= iReqBlockSize;
                r_rw   <= iReqRead;
            end
            // slave's ReadLast must agree with our own count
            if (w_rd_beat && (iDTL_ReadLast != w_last)) begin
                r_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req_fire) w_next = ST_CMD;
            end
            ST_CMD: begin
                if (iDTL_CommandAccept) begin
                    w_next = (r_rw == DTL_CMD_READ) ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_wr_beat && w_last) w_next = ST_IDLE;
            end
            ST_READ: begin
                // internal count ends the burst, not ReadLast
                if (w_rd_beat && w_last) w_next = ST_IDLE;
            end
        endcase
    end

    assign oReqReady             = (r_state == ST_IDLE);
    assign oBusy                 = (r_state != ST_IDLE);
    assign oError                = r_error;

    assign oDTL_CommandValid     = (r_state == ST_CMD);
    assign oDTL_Address          = r_addr;
    assign oDTL_CommandReadWrite = r_rw;
    assign oDTL_BlockSize        = r_size;

    assign oDTL_WriteValid       = w_in_wr & iWrValid;
    assign oWrReady              = w_in_wr & iDTL_WriteAccept;
    assign oDTL_WriteLast        = w_in_wr & w_last;
    assign oDTL_WriteData        = w_in_wr ? iWrData : '0;
    assign oDTL_WriteEnable      = w_in_wr ? iWrEnable : '0;

    assign oRdValid              = w_in_rd & iDTL_ReadValid;
    assign oDTL_ReadAccept       = w_in_rd & iRdReady;
    assign oRdLast               = w_in_rd & w_last;
    assign oRdData               = w_in_rd ? iDTL_ReadData : '0;

endmodule

// File: tb/tb_dtl_master_interface.sv
// Randomised bench for dtl_master_interface with a burst-level model.
// Drives local and slave sides, checks every cycle against expectations.
module tb_dtl_master_interface;

    logic        iClk;
    logic        iReset_n;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqRead;
    logic [31:0] iReqAddr;
    logic [4:0]  iReqBlockSize;
    logic        iWrValid;
    logic        oWrReady;
    logic [31:0] iWrData;
    logic [3:0]  iWrEnable;
    logic        oRdValid;
    logic        iRdReady;
    logic [31:0] oRdData;
    logic        oRdLast;
    logic        oDTL_CommandValid;
    logic        iDTL_CommandAccept;
    logic [31:0] oDTL_Address;
    logic        oDTL_CommandReadWrite;
    logic [4:0]  oDTL_BlockSize;
    logic        iDTL_ReadValid;
    logic        iDTL_ReadLast;
    logic        oDTL_ReadAccept;
    logic [31:0] iDTL_ReadData;
    logic        oDTL_WriteValid;
    logic        oDTL_WriteLast;
    logic        iDTL_WriteAccept;
    logic [3:0]  oDTL_WriteEnable;
    logic [31:0] oDTL_WriteData;
    logic        oBusy;
    logic        oError;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_err    = 1'b0;

    dtl_master_interface dut (
        .iClk                  (iClk),
        .iReset_n              (iReset_n),
        .iReqValid             (iReqValid),
        .oReqReady             (oReqReady),
        .iReqRead              (iReqRead),
        .iReqAddr              (iReqAddr),
        .iReqBlockSize         (iReqBlockSize),
        .iWrValid              (iWrValid),
        .oWrReady              (oWrReady),
        .iWrData               (iWrData),
        .iWrEnable             (iWrEnable),
        .oRdValid              (oRdValid),
        .iRdReady              (iRdReady),
        .oRdData               (oRdData),
        .oRdLast               (oRdLast),
        .oDTL_CommandValid     (oDTL_CommandValid),
        .iDTL_CommandAccept    (iDTL_CommandAccept),
        .oDTL_Address          (oDTL_Address),
        .oDTL_CommandReadWrite (oDTL_CommandReadWrite),
        .oDTL_BlockSize        (oDTL_BlockSize),
        .iDTL_ReadValid        (iDTL_ReadValid),
        .iDTL_ReadLast         (iDTL_ReadLast),
        .oDTL_ReadAccept       (oDTL_ReadAccept),
        .iDTL_ReadData         (iDTL_ReadData),
        .oDTL_WriteValid       (oDTL_WriteValid),
        .oDTL_WriteLast        (oDTL_WriteLast),
        .iDTL_WriteAccept      (iDTL_WriteAccept),
        .oDTL_WriteEnable      (oDTL_WriteEnable),
        .oDTL_WriteData        (oDTL_WriteData),
        .oBusy                 (oBusy),
        .oError                (oError)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iReqValid          = 1'b0;
        iReqRead           = 1'b0;
        iReqAddr           = '0;
        iReqBlockSize      = '0;
        iWrValid           = 1'b0;
        iWrData            = '0;
        iWrEnable          = '0;
        iRdReady           = 1'b0;
        iDTL_CommandAccept = 1'b0;
        iDTL_ReadValid     = 1'b0;
        iDTL_ReadLast      = 1'b0;
        iDTL_ReadData      = '0;
        iDTL_WriteAccept   = 1'b0;
    endtask

    // request + command phase, shared by read and write bursts
    task automatic issue(input bit rd, input logic [31:0] addr,
                         input int size, input int stall);
        step();
        idle_inputs();
        iReqValid     = 1'b1;
        iReqRead      = rd;
        iReqAddr      = addr;
        iReqBlockSize = size[4:0];
        #2;
        chk("req_ready", oReqReady, 1);
        chk("idle_busy", oBusy, 0);
        chk("idle_cmdv", oDTL_CommandValid, 0);
        step();
        idle_inputs();
        iWrValid         = 1'b1;
        iDTL_WriteAccept = 1'b1;
        iDTL_ReadValid   = 1'b1;
        iRdReady         = 1'b1;
        for (int k = 0; k <= stall; k++) begin
            iDTL_CommandAccept = (k == stall);
            #2;
            chk("cmd_valid", oDTL_CommandValid, 1);
            chk("cmd_addr", oDTL_Address, addr);
            chk("cmd_size", oDTL_BlockSize, size[4:0]);
            chk("cmd_rw", oDTL_CommandReadWrite, rd);
            chk("cmd_no_wr", {oDTL_WriteValid, oWrReady}, 0);
            chk("cmd_no_rd", {oRdValid, oDTL_ReadAccept}, 0);
            chk("cmd_busy", oBusy, 1);
            step();
        end
        idle_inputs();
    endtask

    task automatic burst_done(input string tag);
        idle_inputs();
        #2;
        chk({tag, "_end_idle"}, {oBusy, oReqReady}, 2'b01);
        chk({tag, "_end_err"}, oError, m_err);
        chk({tag, "_end_chan"}, {oDTL_WriteValid, oRdValid,
            oDTL_CommandValid}, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input int size,
                            input int stall, input int pv, input int pa,
                            input bit fixed, input logic [31:0] dbase);
        int i;
        int cyc;
        bit v;
        bit a;
        logic [31:0] d;
        logic [3:0]  e;
        issue(1'b0, addr, size, stall);
        i = 0;
        cyc = 0;
        while (i <= size && cyc < 2000) begin
            v = fixed ? 1'b1 : ($urandom_range(99) < pv);
            a = fixed ? 1'b1 : ($urandom_range(99) < pa);
            d = fixed ? dbase + i : $urandom;
            e = $urandom;
            iWrValid = v;
            iDTL_WriteAccept = a;
            iWrData = d;
            iWrEnable = e;
            #2;
            chk("wr_valid", oDTL_WriteValid, v);
            chk("wr_ready", oWrReady, a);
            chk("wr_data", oDTL_WriteData, d);
            chk("wr_en", oDTL_WriteEnable, e);
            chk("wr_last", oDTL_WriteLast, (i == size));
            chk("wr_no_rd", oRdValid, 0);
            if (v && a) i++;
            cyc++;
            step();
        end
        if (cyc >= 2000) chk("wr_timeout", 0, 1);
        burst_done("wr");
    endtask

    // pr<0: iRdReady toggles 1,0,1,... ; mism<0: ReadLast is honest,
    // otherwise ReadLast is asserted on beat mism only
    task automatic do_read(input logic [31:0] addr, input int size,
                           input int stall, input int pv, input int pr,
                           input int mism, input bit fixed,
                           input logic [31:0] dfix);
        int i;
        int cyc;
        bit v;
        bit r;
        bit lf;
        logic [31:0] d;
        issue(1'b1, addr, size, stall);
        i = 0;
        cyc = 0;
        while (i <= size && cyc < 2000) begin
            v = fixed ? 1'b1 : ($urandom_range(99) < pv);
            if (pr < 0) r = (cyc % 2 == 0);
            else r = ($urandom_range(99) < pr);
            d = fixed ? dfix : $urandom;
            lf = (mism < 0) ? (i == size) : (i == mism);
            iDTL_ReadValid = v;
            iRdReady = r;
            iDTL_ReadData = d;
            iDTL_ReadLast = lf;
            #2;
            chk("rd_valid", oRdValid, v);
            chk("rd_accept", oDTL_ReadAccept, r);
            chk("rd_data", oRdData, d);
            chk("rd_last", oRdLast, (i == size));
            chk("rd_err", oError, m_err);
            chk("rd_no_wr", oDTL_WriteValid, 0);
            if (v && r) begin
                if (lf != (i == size)) m_err = 1'b1;
                i++;
            end
            cyc++;
            step();
        end
        if (cyc >= 2000) chk("rd_timeout", 0, 1);
        burst_done("rd");
    endtask

    initial begin
        idle_inputs();
        iReset_n = 1'b0;
        #3;
        chk("rst_ready", oReqReady, 1);
        chk("rst_outs", {oDTL_CommandValid, oDTL_WriteValid,
            oDTL_WriteLast, oDTL_ReadAccept, oRdValid, oWrReady, oBusy}, 0);
        chk("rst_err", oError, 0);
        chk("rst_latch", {oDTL_Address, oDTL_BlockSize,
            oDTL_CommandReadWrite}, 0);
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iReset_n = 1'b1;

        do_write(32'h100, 3, 0, 100, 100, 1'b1, 32'hA0);
        do_read(32'h200, 0, 0, 100, 100, -1, 1'b1, 32'hDEADBEEF);
        do_read(32'h300, 2, 0, 100, -1, -1, 1'b0, 0);
        do_write(32'h400, 2, 5, 100, 100, 1'b0, 0);
        do_read(32'h500, 31, 1, 70, 70, -1, 1'b0, 0);
        do_write(32'h600, 31, 0, 80, 80, 1'b0, 0);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(1) == 1) begin
                do_read($urandom & ~32'h3, $urandom_range(31),
                        $urandom_range(3), $urandom_range(100, 40),
                        $urandom_range(100, 40), -1, 1'b0, 0);
            end else begin
                do_write($urandom & ~32'h3, $urandom_range(31),
                         $urandom_range(3), $urandom_range(100, 40),
                         $urandom_range(100, 40), 1'b0, 0);
            end
        end

        do_read(32'h700, 1, 0, 100, 100, 0, 1'b0, 0);
        chk("err_set", m_err, 1);
        do_write(32'h800, 1, 0, 100, 100, 1'b0, 0);

        issue(1'b0, 32'h900, 3, 0);
        iWrValid = 1'b1;
        iDTL_WriteAccept = 1'b1;
        iWrEnable = 4'hF;
        for (int b = 0; b < 2; b++) begin
            iWrData = 32'hB0 + b;
            #2;
            chk("rstw_valid", oDTL_WriteValid, 1);
            step();
        end
        #1;
        iReset_n = 1'b0;
        #1;
        chk("arst_outs", {oDTL_CommandValid, oDTL_WriteValid,
            oDTL_WriteLast, oDTL_ReadAccept, oRdValid, oWrReady, oBusy}, 0);
        chk("arst_data", {oDTL_WriteData, oDTL_WriteEnable}, 0);
        chk("arst_latch", {oDTL_Address, oDTL_BlockSize}, 0);
        chk("arst_err", oError, 0);
        m_err = 1'b0;
        idle_inputs();
        @(negedge iClk);
        iReset_n = 1'b1;
        #1;
        chk("arst_ready", oReqReady, 1);
        do_write(32'hA00, 3, 1, 100, 100, 1'b1, 32'hC0);
        do_read(32'hB00, 4, 0, 60, 60, -1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
